result_collector: RTL and testbench
===================================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port conv_valid, input, 1 bit: convolution result present on conv_result this cycle.
REQ-004 SHALL have port conv_result, input, 12 bits, two's-complement signed: result for the current 3x3 window position.
REQ-005 SHALL have port conv_ready, output, 1 bit: block can accept a result this cycle.
REQ-006 SHALL have port calc_done, output, 1 bit: one-cycle pulse per accepted result; advances the upstream window select.
REQ-007 SHALL have port tile_ready, input, 1 bit: downstream accepts the presented tile.
REQ-008 SHALL have port tile_valid, output, 1 bit: a complete 2x2 output tile is presented.
REQ-009 SHALL have port out_pixels, output, [1:0][1:0][7:0]: 2x2 tile of 8-bit results, index [row][col].
REQ-010 SHALL have port tile_count, output, 8 bits: number of tiles handed off, modulo 256.

Function
REQ-011 SHALL implement a two-state machine: FILL (collecting) and FULL (tile presented).
REQ-012 SHALL drive conv_ready = 1 in FILL and 0 in FULL.
REQ-013 SHALL accept a result only when conv_valid and conv_ready are both 1 at a rising clk edge; conv_valid while conv_ready = 0 SHALL be ignored with no state change.
REQ-014 SHALL keep a 2-bit position counter pos, 0..3, mapped pos0->[0][0], pos1->[0][1], pos2->[1][0], pos3->[1][1], matching the upstream window order.
REQ-015 SHALL, on each accept, write the converted result into out_pixels[pos] and increment pos at the same edge.
REQ-016 SHALL assert calc_done for exactly the one cycle following each accept; registered output, latency 1.
REQ-017 SHALL, on the accept with pos = 3, wrap pos to 0 and transition to FULL, so that tile_valid = 1 in the cycle following the fourth accept.
REQ-018 SHALL, in FULL, hold out_pixels and tile_valid stable until tile_ready = 1 at a rising edge.
REQ-019 SHALL, on tile_ready = 1 in FULL, return to FILL, deassert tile_valid, and increment tile_count (255 wraps to 0), all at the same edge.
REQ-020 SHALL ignore tile_ready while in FILL.
REQ-021 SHALL NOT accept a result in the cycle that FULL is exited; conv_ready rises in the cycle after the handshake, so a tile never passes through in zero cycles.
REQ-022 SHALL leave out_pixels holding the previous tile's values in FILL until each position is overwritten.

Reset
REQ-023 SHALL, while n_rst = 0 and independent of clk, force state FILL, pos = 0, out_pixels = all zeros, tile_count = 0, tile_valid = 0, calc_done = 0, conv_ready = 1.
REQ-024 SHALL discard a partially collected tile when reset is asserted mid-fill or mid-FULL; no tile_count increment.
REQ-025 SHALL resume operation on the first rising edge after n_rst is deasserted.

Configuration
REQ-026 SHALL, when macro RESULT_SAT_EN is defined, clamp conv_result to 8 bits: negative values -> 0, values > 255 -> 255, otherwise unchanged.
REQ-027 SHALL, when RESULT_SAT_EN is undefined, store conv_result[7:0] (truncation, no clamping); all other behaviour is identical.

Verification
REQ-028 Reset: drive n_rst = 0 mid-fill after 2 accepts -> outputs as REQ-023 immediately; the next 4 accepts produce one tile; tile_count = 1 after its handshake.
REQ-029 Fill: accept 10, 20, 30, 40 on consecutive cycles -> calc_done pulses each following cycle; tile_valid = 1 one cycle after the fourth accept; out_pixels = [[10,20],[30,40]].
REQ-030 Backpressure: hold tile_ready = 0 for 5 cycles with conv_valid = 1 and conv_result = 99 -> conv_ready = 0, out_pixels unchanged, no calc_done; then tile_ready = 1 -> tile_valid = 0 and conv_ready = 1 next cycle.
REQ-031 Saturation: results -5, 300, 255, 0 -> with RESULT_SAT_EN tile = [[0,255],[255,0]]; without it tile = [[251,44],[255,0]].
REQ-032 Wrap: complete 256 tile handshakes -> tile_count reads 0; 257 handshakes -> reads 1.
REQ-033 Idle gaps: accepts separated by random idle cycles, with tile_ready asserted in FILL -> tile contents in order, tile_ready ignored in FILL, exactly one calc_done per accept.

Source files
------------

// File: rtl/result_collector.sv
// ============================================================================
//  Module   : result_collector
//  Purpose  : Gathers four convolution results into a 2x2 tile of 8-bit pixels
//             and hands the tile off with a valid/ready handshake.
//             Optional macro RESULT_SAT_EN clamps results to 0..255 instead of
//             truncating them to the low byte.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module result_collector (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   conv_valid,
  input  logic signed [11:0]     conv_result,
  output logic                   conv_ready,
  output logic                   calc_done,
  input  logic                   tile_ready,
  output logic                   tile_valid,
  output logic [1:0][1:0][7:0]   out_pixels,
  output logic [7:0]             tile_count
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             pos_q, pos_d;
  logic [1:0][1:0][7:0]   pix_q, pix_d;
  logic                   done_q, done_d;
  logic [7:0]             count_q, count_d;
  logic [7:0]             w_pix8;

`ifdef RESULT_SAT_EN
  always_comb begin
    w_pix8 = conv_result[7:0];
    if (conv_result[11]) begin
      w_pix8 = 8'd0;
    end else if (conv_result[10:8] != 3'd0) begin
      w_pix8 = 8'd255;
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^conv_result[11:8];

  always_comb begin
    w_pix8 = conv_result[7:0];
  end
`endif

  // conv_ready is a pure decode of the state, so it is low for the whole
  // handshake cycle and a tile can never be bypassed in zero cycles.
  assign conv_ready = (state_q == FILL);
  assign tile_valid = (state_q == FULL);
  assign calc_done  = done_q;
  assign out_pixels = pix_q;
  assign tile_count = count_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    pix_d   = pix_q;
    done_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      FILL: begin
        if (conv_valid) begin
          pix_d[pos_q[1]][pos_q[0]] = w_pix8;
          pos_d  = pos_q + 2'd1;
          done_d = 1'b1;
          if (pos_q == 2'd3) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (tile_ready) begin
          state_d = FILL;
          count_d = count_q + 8'd1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= FILL;
      pos_q   <= 2'd0;
      pix_q   <= '0;
      done_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      pix_q   <= pix_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_collector.sv
// ============================================================================
//  Module   : tb_result_collector
//  Purpose  : Self-checking bench for result_collector (table-driven vectors
//             plus hand-written reset, idle-gap and counter-wrap sequences).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_collector;

  logic                 clk;
  logic                 n_rst;
  logic                 conv_valid;
  logic signed [11:0]   conv_result;
  logic                 conv_ready;
  logic                 calc_done;
  logic                 tile_ready;
  logic                 tile_valid;
  logic [1:0][1:0][7:0] out_pixels;
  logic [7:0]           tile_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cd_cnt   = 0;

`ifdef RESULT_SAT_EN
  localparam logic [7:0] E_NEG5 = 8'd0;
  localparam logic [7:0] E_300  = 8'd255;
`else
  localparam logic [7:0] E_NEG5 = 8'd251;
  localparam logic [7:0] E_300  = 8'd44;
`endif

  typedef struct {
    logic        v;
    logic [11:0] r;
    logic        tr;
    logic        e_rdy;
    logic        e_done;
    logic        e_tv;
    logic [31:0] e_pix;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[16];

  result_collector dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .conv_valid  (conv_valid),
    .conv_result (conv_result),
    .conv_ready  (conv_ready),
    .calc_done   (calc_done),
    .tile_ready  (tile_ready),
    .tile_valid  (tile_valid),
    .out_pixels  (out_pixels),
    .tile_count  (tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs a tile given as [0][0], [0][1], [1][0], [1][1].
  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [11:0] r, input logic tr);
    conv_valid  = v;
    conv_result = r;
    tile_ready  = tr;
    @(posedge clk);
    #1;
    if (calc_done) cd_cnt++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ready"}, 32'(conv_ready), 32'd1);
    chk({tag, " done"},  32'(calc_done),  32'd0);
    chk({tag, " tv"},    32'(tile_valid), 32'd0);
    chk({tag, " pix"},   out_pixels,      32'd0);
    chk({tag, " cnt"},   32'(tile_count), 32'd0);
  endtask

  task automatic quick_tile();
    cyc(1'b1, 12'd1, 1'b0);
    cyc(1'b1, 12'd2, 1'b0);
    cyc(1'b1, 12'd3, 1'b0);
    cyc(1'b1, 12'd4, 1'b0);
    cyc(1'b0, 12'd0, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fill and backpressure vectors; outputs are those seen after the edge.
    tbl[0]  = '{1'b1, 12'd10,  1'b0, 1'b1, 1'b1, 1'b0, mk(10, 0, 0, 0),    8'd0};
    tbl[1]  = '{1'b1, 12'd20,  1'b0, 1'b1, 1'b1, 1'b0, mk(10, 20, 0, 0),   8'd0};
    tbl[2]  = '{1'b1, 12'd30,  1'b1, 1'b1, 1'b1, 1'b0, mk(10, 20, 30, 0),  8'd0};
    tbl[3]  = '{1'b1, 12'd40,  1'b0, 1'b0, 1'b1, 1'b1, mk(10, 20, 30, 40), 8'd0};
    for (int i = 4; i < 9; i++)
      tbl[i] = '{1'b1, 12'd99, 1'b0, 1'b0, 1'b0, 1'b1, mk(10, 20, 30, 40), 8'd0};
    tbl[9]  = '{1'b1, 12'd99,  1'b1, 1'b1, 1'b0, 1'b0, mk(10, 20, 30, 40), 8'd1};
    tbl[10] = '{1'b0, 12'd0,   1'b1, 1'b1, 1'b0, 1'b0, mk(10, 20, 30, 40), 8'd1};
    tbl[11] = '{1'b1, 12'hFFB, 1'b0, 1'b1, 1'b1, 1'b0, mk(E_NEG5, 20, 30, 40),     8'd1};
    tbl[12] = '{1'b1, 12'd300, 1'b0, 1'b1, 1'b1, 1'b0, mk(E_NEG5, E_300, 30, 40),  8'd1};
    tbl[13] = '{1'b1, 12'd255, 1'b0, 1'b1, 1'b1, 1'b0, mk(E_NEG5, E_300, 255, 40), 8'd1};
    tbl[14] = '{1'b1, 12'd0,   1'b0, 1'b0, 1'b1, 1'b1, mk(E_NEG5, E_300, 255, 0),  8'd1};
    tbl[15] = '{1'b1, 12'd7,   1'b1, 1'b1, 1'b0, 1'b0, mk(E_NEG5, E_300, 255, 0),  8'd2};

    n_rst = 1'b0; conv_valid = 1'b0; conv_result = '0; tile_ready = 1'b0;
    #2;
    chk_reset_vals("por");
    @(posedge clk); #1;
    n_rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].v, tbl[i].r, tbl[i].tr);
      chk($sformatf("vec%0d ready", i), 32'(conv_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d done", i),  32'(calc_done),  32'(tbl[i].e_done));
      chk($sformatf("vec%0d tv", i),    32'(tile_valid), 32'(tbl[i].e_tv));
      chk($sformatf("vec%0d pix", i),   out_pixels,      tbl[i].e_pix);
      chk($sformatf("vec%0d cnt", i),   32'(tile_count), 32'(tbl[i].e_cnt));
    end

    // Reset mid-fill, asserted between clock edges.
    cyc(1'b1, 12'd1, 1'b0);
    cyc(1'b1, 12'd2, 1'b0);
    #2; n_rst = 1'b0; #1;
    chk_reset_vals("rst_fill");
    @(posedge clk); #1;
    n_rst = 1'b1;
    cyc(1'b1, 12'd5, 1'b0);
    cyc(1'b1, 12'd6, 1'b0);
    cyc(1'b1, 12'd7, 1'b0);
    chk("rst_fill partial tv", 32'(tile_valid), 32'd0);
    cyc(1'b1, 12'd8, 1'b0);
    chk("rst_fill tv", 32'(tile_valid), 32'd1);
    chk("rst_fill pix", out_pixels, mk(5, 6, 7, 8));
    cyc(1'b0, 12'd0, 1'b1);
    chk("rst_fill cnt", 32'(tile_count), 32'd1);
    chk("rst_fill tv_off", 32'(tile_valid), 32'd0);

    // Reset while a tile is presented.
    quick_tile();
    cyc(1'b1, 12'd9, 1'b0); cyc(1'b1, 12'd9, 1'b0);
    cyc(1'b1, 12'd9, 1'b0); cyc(1'b1, 12'd9, 1'b0);
    chk("rst_full pre tv", 32'(tile_valid), 32'd1);
    #2; n_rst = 1'b0; #1;
    chk_reset_vals("rst_full");
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Idle gaps with tile_ready held high throughout.
    cd_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) cyc(1'b0, 12'd0, 1'b1);
      if (k == 3) chk("idle cnt_in_fill", 32'(tile_count), 32'd0);
      cyc(1'b1, 12'(50 + k), 1'b1);
    end
    chk("idle tv", 32'(tile_valid), 32'd1);
    chk("idle pix", out_pixels, mk(50, 51, 52, 53));
    cyc(1'b0, 12'd0, 1'b1);
    cyc(1'b0, 12'd0, 1'b0);
    chk("idle cnt", 32'(tile_count), 32'd1);
    chk("idle done_pulses", 32'(cd_cnt), 32'd4);

    // Tile counter wrap.
    #2; n_rst = 1'b0; #1;
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int t = 0; t < 255; t++) quick_tile();
    chk("wrap 255", 32'(tile_count), 32'd255);
    quick_tile();
    chk("wrap 256", 32'(tile_count), 32'd0);
    quick_tile();
    chk("wrap 257", 32'(tile_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
